// File: rtl/jelly_ring_bus_request_scheduler.sv
// ---------------------------------------------------------------------------
// jelly_ring_bus_request_scheduler
//
// This block lets REQ_NUM local requesters share one slave port of the
// ring-bus crossbar.
//   - Down path: a round-robin arbiter feeds a one-entry registered output
//     stage. There is one cycle of latency from grant to b_down_valid.
//   - Up path: a combinational, zero-latency router. An order FIFO records
//     which requester was granted, so responses go back in issue order.
//   - Credit control: the FIFO occupancy ("outstanding") limits the number of
//     transactions in flight to MAX_OUTSTANDING.
//
// Ports
//   reset, clk, cke            asynchronous active-high reset, clock, clock enable
//   r_down_id_to/data/valid    per-requester request (input)
//   r_down_ready               per-requester accept, one-hot or zero
//   r_up_id_from/data          response id/data, broadcast to every lane
//   r_up_valid/ready           per-requester response handshake
//   b_down_id_to/data/valid    request towards the crossbar
//   b_down_ready               crossbar accepts the request
//   b_up_id_from/data/valid    response from the crossbar
//   b_up_ready                 response accept towards the crossbar
//   outstanding                order-FIFO occupancy
//   orphan_err                 sticky flag: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module jelly_ring_bus_request_scheduler #(
  parameter int REQ_NUM         = 4,
  parameter int REQ_ID_WIDTH    = 2,
  parameter int M_ID_WIDTH      = 2,
  parameter int DOWN_DATA_WIDTH = 32,
  parameter int UP_DATA_WIDTH   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                               reset,
  input  logic                               clk,
  input  logic                               cke,

  input  logic [REQ_NUM*M_ID_WIDTH-1:0]      r_down_id_to,
  input  logic [REQ_NUM*DOWN_DATA_WIDTH-1:0] r_down_data,
  input  logic [REQ_NUM-1:0]                 r_down_valid,
  output logic [REQ_NUM-1:0]                 r_down_ready,

  output logic [REQ_NUM*M_ID_WIDTH-1:0]      r_up_id_from,
  output logic [REQ_NUM*UP_DATA_WIDTH-1:0]   r_up_data,
  output logic [REQ_NUM-1:0]                 r_up_valid,
  input  logic [REQ_NUM-1:0]                 r_up_ready,

  output logic [M_ID_WIDTH-1:0]              b_down_id_to,
  output logic [DOWN_DATA_WIDTH-1:0]         b_down_data,
  output logic                               b_down_valid,
  input  logic                               b_down_ready,

  input  logic [M_ID_WIDTH-1:0]              b_up_id_from,
  input  logic [UP_DATA_WIDTH-1:0]           b_up_data,
  input  logic                               b_up_valid,
  output logic                               b_up_ready,

  output logic [CNT_WIDTH-1:0]               outstanding,
  output logic                               orphan_err
);

  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Per-lane views of the packed request buses.
  logic [M_ID_WIDTH-1:0]      down_id_arr   [REQ_NUM];
  logic [DOWN_DATA_WIDTH-1:0] down_data_arr [REQ_NUM];

  // State
  logic [REQ_ID_WIDTH-1:0]    last_reg;
  logic                       out_valid_reg;
  logic [M_ID_WIDTH-1:0]      out_id_reg;
  logic [DOWN_DATA_WIDTH-1:0] out_data_reg;
  logic [REQ_ID_WIDTH-1:0]    fifo_mem [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]       wr_ptr_reg;
  logic [PTR_WIDTH-1:0]       rd_ptr_reg;
  logic [CNT_WIDTH-1:0]       count_reg;
  logic                       orphan_reg;

  // Datapath
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [REQ_ID_WIDTH-1:0]    head;
  logic                       head_ready;
  logic                       up_pop;
  logic                       grant_en;
  logic                       grant;
  logic                       found;
  logic [REQ_ID_WIDTH-1:0]    winner;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_lane
      assign down_id_arr[gi]   = r_down_id_to[gi*M_ID_WIDTH +: M_ID_WIDTH];
      assign down_data_arr[gi] = r_down_data[gi*DOWN_DATA_WIDTH +: DOWN_DATA_WIDTH];

      // The response id/data go to every lane. Only the head requester
      // receives valid.
      assign r_up_id_from[gi*M_ID_WIDTH +: M_ID_WIDTH]     = b_up_id_from;
      assign r_up_data[gi*UP_DATA_WIDTH +: UP_DATA_WIDTH]  = b_up_data;
      assign r_up_valid[gi]   = ~fifo_empty & b_up_valid & (head == REQ_ID_WIDTH'(gi));
      assign r_down_ready[gi] = grant & (winner == REQ_ID_WIDTH'(gi));
    end
  endgenerate

  // ---------------- up path ----------------
  // Full and empty come from the occupancy count, so the pointers can simply
  // wrap and do not need an extra bit.
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_WIDTH'(MAX_OUTSTANDING));
  assign head       = fifo_mem[rd_ptr_reg];
  assign head_ready = r_up_ready[head];

  // When the FIFO is empty there is no owner for a response. It is accepted
  // and dropped so the crossbar never stalls.
  assign b_up_ready = cke & (fifo_empty | head_ready);
  assign up_pop     = cke & ~fifo_empty & b_up_valid & head_ready;

  // ---------------- down path ----------------
  // A pop in the same cycle frees one credit, so a full FIFO can still grant.
  assign grant_en = cke & (~out_valid_reg | b_down_ready) & (~fifo_full | up_pop);
  assign grant    = grant_en & found;

  // Round-robin: scan from last+1 upward, modulo REQ_NUM.
  always_comb begin
    logic [REQ_ID_WIDTH-1:0] cand;
    found  = 1'b0;
    winner = last_reg;
    cand   = '0;
    for (int i = 1; i <= REQ_NUM; i++) begin
      cand = REQ_ID_WIDTH'((int'(last_reg) + i) % REQ_NUM);
      if (!found && r_down_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_reg      <= REQ_ID_WIDTH'(REQ_NUM - 1);
      out_valid_reg <= 1'b0;
      out_id_reg    <= '0;
      out_data_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      orphan_reg    <= 1'b0;
    end else if (cke) begin
      if (grant) begin
        out_valid_reg <= 1'b1;
        out_id_reg    <= down_id_arr[winner];
        out_data_reg  <= down_data_arr[winner];
        last_reg      <= winner;
        wr_ptr_reg    <= ptr_inc(wr_ptr_reg);
      end else if (b_down_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (up_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end

      if (grant && !up_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (!grant && up_pop) begin
        count_reg <= count_reg - 1'b1;
      end

      if (fifo_empty && b_up_valid) begin
        orphan_reg <= 1'b1;
      end
    end
  end

  // The order-FIFO storage has no reset. Only the pointers define its
  // contents.
  always_ff @(posedge clk) begin
    if (grant) begin
      fifo_mem[wr_ptr_reg] <= winner;
    end
  end

  assign b_down_valid = out_valid_reg;
  assign b_down_id_to = out_id_reg;
  assign b_down_data  = out_data_reg;
  assign outstanding  = count_reg;
  assign orphan_err   = orphan_reg;

endmodule

// File: tb/tb_jelly_ring_bus_request_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for jelly_ring_bus_request_scheduler.
// A queue-based model predicts every output on each falling edge.
// Directed literal checks pin the important cycles.
// Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_jelly_ring_bus_request_scheduler;

  localparam int N    = 4;
  localparam int MAXO = 4;

  logic          reset;
  logic          clk;
  logic          cke;
  logic [N*2-1:0]  r_down_id_to;
  logic [N*32-1:0] r_down_data;
  logic [N-1:0]    r_down_valid;
  logic [N-1:0]    r_down_ready;
  logic [N*2-1:0]  r_up_id_from;
  logic [N*16-1:0] r_up_data;
  logic [N-1:0]    r_up_valid;
  logic [N-1:0]    r_up_ready;
  logic [1:0]      b_down_id_to;
  logic [31:0]     b_down_data;
  logic            b_down_valid;
  logic            b_down_ready;
  logic [1:0]      b_up_id_from;
  logic [15:0]     b_up_data;
  logic            b_up_valid;
  logic            b_up_ready;
  logic [2:0]      outstanding;
  logic            orphan_err;

  int total = 0;
  int bad   = 0;

  jelly_ring_bus_request_scheduler dut (
    .reset        (reset),
    .clk          (clk),
    .cke          (cke),
    .r_down_id_to (r_down_id_to),
    .r_down_data  (r_down_data),
    .r_down_valid (r_down_valid),
    .r_down_ready (r_down_ready),
    .r_up_id_from (r_up_id_from),
    .r_up_data    (r_up_data),
    .r_up_valid   (r_up_valid),
    .r_up_ready   (r_up_ready),
    .b_down_id_to (b_down_id_to),
    .b_down_data  (b_down_data),
    .b_down_valid (b_down_valid),
    .b_down_ready (b_down_ready),
    .b_up_id_from (b_up_id_from),
    .b_up_data    (b_up_data),
    .b_up_valid   (b_up_valid),
    .b_up_ready   (b_up_ready),
    .outstanding  (outstanding),
    .orphan_err   (orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_q[$];     // requester indices in issue order
  bit          m_v;        // output stage holds a request
  logic [1:0]  m_id;
  logic [31:0] m_data;
  int          m_last;
  bit          m_orphan;

  always @(negedge clk) begin
    bit         empty;
    int         h;
    bit         pop;
    int         win;
    logic [3:0] e_rdr;
    logic [3:0] e_ruv;
    logic       e_bur;

    if (reset) begin
      m_q.delete();
      m_v      = 1'b0;
      m_last   = N - 1;
      m_orphan = 1'b0;
    end

    empty = (m_q.size() == 0);
    h     = empty ? 0 : m_q[0];
    e_bur = cke && (empty || r_up_ready[h]);
    e_ruv = 4'b0;
    if (!empty && b_up_valid) e_ruv[h] = 1'b1;
    pop   = cke && !empty && b_up_valid && r_up_ready[h];

    win = -1;
    if (cke && (!m_v || b_down_ready) && (m_q.size() < MAXO || pop)) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (win < 0 && r_down_valid[idx]) win = idx;
      end
    end
    e_rdr = 4'b0;
    if (win >= 0) e_rdr[win] = 1'b1;

    chk("m_r_down_ready", 64'(r_down_ready), 64'(e_rdr));
    chk("m_b_up_ready", 64'(b_up_ready), 64'(e_bur));
    chk("m_r_up_valid", 64'(r_up_valid), 64'(e_ruv));
    chk("m_b_down_valid", 64'(b_down_valid), 64'(m_v));
    chk("m_outstanding", 64'(outstanding), 64'(m_q.size()));
    chk("m_orphan_err", 64'(orphan_err), 64'(m_orphan));
    if (m_v) begin
      chk("m_b_down_data", 64'(b_down_data), 64'(m_data));
      chk("m_b_down_id_to", 64'(b_down_id_to), 64'(m_id));
    end
    if (!empty) begin
      for (int l = 0; l < N; l++) begin
        chk("m_r_up_data", 64'(r_up_data[l*16 +: 16]), 64'(b_up_data));
        chk("m_r_up_id_from", 64'(r_up_id_from[l*2 +: 2]), 64'(b_up_id_from));
      end
    end

    if (!reset && cke) begin
      if (pop) begin
        $display("response to req=%0d data=%h", h, b_up_data);
        void'(m_q.pop_front());
      end
      if (win >= 0) begin
        $display("grant req=%0d id=%0d data=%h", win, r_down_id_to[win*2 +: 2], r_down_data[win*32 +: 32]);
        m_q.push_back(win);
        m_v    = 1'b1;
        m_id   = r_down_id_to[win*2 +: 2];
        m_data = r_down_data[win*32 +: 32];
        m_last = win;
      end else if (b_down_ready) begin
        m_v = 1'b0;
      end
      if (empty && b_up_valid) m_orphan = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    cke          = 1'b1;
    r_down_valid = '0;
    b_down_ready = 1'b1;
    r_up_ready   = '1;
    b_up_valid   = 1'b0;
    b_up_data    = '0;
    b_up_id_from = '0;
    for (int i = 0; i < N; i++) begin
      r_down_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      r_down_id_to[i*2 +: 2]  = 2'(i);
    end

    // reset state
    step(); step(); peek();
    chk("rst_b_down_valid", 64'(b_down_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_orphan", 64'(orphan_err), 64'd0);

    // 1/2: round robin up to the credit limit
    step(); reset = 1'b0; r_down_valid = 4'hF; peek();
    chk("t1_grant0", 64'(r_down_ready), 64'h1);
    chk("t1_latency", 64'(b_down_valid), 64'd0);
    step(); peek();
    chk("t1_grant1", 64'(r_down_ready), 64'h2);
    chk("t1_first_valid", 64'(b_down_valid), 64'd1);
    chk("t1_first_data", 64'(b_down_data), 64'h1000_0000);
    step(); peek(); chk("t1_grant2", 64'(r_down_ready), 64'h4);
    step(); peek(); chk("t1_grant3", 64'(r_down_ready), 64'h8);
    step(); peek();
    chk("t2_full_noready", 64'(r_down_ready), 64'h0);
    chk("t2_full_count", 64'(outstanding), 64'd4);
    step(); peek();
    chk("t2_still_blocked", 64'(r_down_ready), 64'h0);
    step(); b_up_valid = 1'b1; b_up_data = 16'h1234; b_up_id_from = 2'd1; peek();
    chk("t2_pop_lane0", 64'(r_up_valid), 64'h1);
    chk("t2_pop_bready", 64'(b_up_ready), 64'd1);
    chk("t1_grant0_again", 64'(r_down_ready), 64'h1);
    chk("t2_count_same", 64'(outstanding), 64'd4);
    step(); r_down_valid = '0; peek();
    chk("t2_count_after", 64'(outstanding), 64'd4);
    chk("t2_regrant_data", 64'(b_down_data), 64'h1000_0000);
    chk("t2_head1", 64'(r_up_valid), 64'h2);
    step(); peek(); chk("t2_head2", 64'(r_up_valid), 64'h4);
    step(); peek(); chk("t2_head3", 64'(r_up_valid), 64'h8);
    step(); peek(); chk("t2_head0", 64'(r_up_valid), 64'h1);
    step(); b_up_valid = 1'b0; peek();
    chk("t2_drained", 64'(outstanding), 64'd0);

    // 3: issue order routing, with back-pressure on the head lane
    step(); r_down_valid = 4'b0100; r_down_data[2*32 +: 32] = 32'hCAFE_0002; r_up_ready = 4'b1011; peek();
    chk("t3_grant2", 64'(r_down_ready), 64'h4);
    step(); r_down_valid = 4'b0001; peek();
    chk("t3_grant0", 64'(r_down_ready), 64'h1);
    step(); r_down_valid = '0; b_up_valid = 1'b1; b_up_data = 16'hAAAA; b_up_id_from = 2'd3; peek();
    chk("t3_valid_lane2", 64'(r_up_valid), 64'h4);
    chk("t3_backpressure", 64'(b_up_ready), 64'd0);
    chk("t3_count2", 64'(outstanding), 64'd2);
    step(); r_up_ready = '1; peek();
    chk("t3_lane2_again", 64'(r_up_valid), 64'h4);
    chk("t3_data_aaaa", 64'(r_up_data[2*16 +: 16]), 64'hAAAA);
    chk("t3_bready", 64'(b_up_ready), 64'd1);
    step(); b_up_data = 16'h5555; peek();
    chk("t3_valid_lane0", 64'(r_up_valid), 64'h1);
    chk("t3_data_5555", 64'(r_up_data[0*16 +: 16]), 64'h5555);
    step(); b_up_valid = 1'b0; peek();
    chk("t3_drained", 64'(outstanding), 64'd0);

    // 4: downstream stall
    step(); r_down_valid = 4'b0010; r_down_data[1*32 +: 32] = 32'hB0B0_0001; peek();
    chk("t4_grant1", 64'(r_down_ready), 64'h2);
    step(); r_down_valid = 4'b1000; b_down_ready = 1'b0; peek();
    chk("t4_stall_valid", 64'(b_down_valid), 64'd1);
    chk("t4_stall_nogrant", 64'(r_down_ready), 64'h0);
    for (int c = 0; c < 4; c++) begin
      step(); peek();
      chk("t4_stall_data", 64'(b_down_data), 64'hB0B0_0001);
      chk("t4_stall_id", 64'(b_down_id_to), 64'd1);
    end
    step(); b_down_ready = 1'b1; peek();
    chk("t4_grant_same_cycle", 64'(r_down_ready), 64'h8);
    step(); r_down_valid = '0; peek();
    chk("t4_next_data", 64'(b_down_data), 64'h1000_0003);
    chk("t4_count", 64'(outstanding), 64'd2);

    // 6: clock enable freeze, then reset mid-transfer
    step(); cke = 1'b0; r_down_valid = 4'b0001; peek();
    chk("t6_cke_rdr", 64'(r_down_ready), 64'h0);
    chk("t6_cke_bur", 64'(b_up_ready), 64'd0);
    step(); peek();
    chk("t6_cke_count", 64'(outstanding), 64'd2);
    chk("t6_cke_hold", 64'(b_down_data), 64'h1000_0003);
    step(); cke = 1'b1; peek();
    chk("t6_resume_grant", 64'(r_down_ready), 64'h1);
    step(); r_down_valid = '0; reset = 1'b1; peek();
    chk("t6_rst_valid", 64'(b_down_valid), 64'd0);
    chk("t6_rst_count", 64'(outstanding), 64'd0);
    step(); reset = 1'b0;

    // 5: orphan response
    step(); b_up_valid = 1'b1; b_up_data = 16'hDEAD; peek();
    chk("t5_bready", 64'(b_up_ready), 64'd1);
    chk("t5_no_rvalid", 64'(r_up_valid), 64'h0);
    step(); b_up_valid = 1'b0; peek();
    chk("t5_orphan_set", 64'(orphan_err), 64'd1);
    step(); step(); peek();
    chk("t5_orphan_sticky", 64'(orphan_err), 64'd1);
    step(); reset = 1'b1; peek();
    chk("t5_orphan_clear", 64'(orphan_err), 64'd0);
    step(); reset = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
